axi_lite_gpio_slave: RTL and testbench

AXI_LITE_GPIO_SLAVE -- requirements
Module: axi_lite_gpio_slave

---
 rtl/axi_lite_gpio_slave.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_axi_lite_gpio_slave.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_gpio_slave.sv
// AXI4-Lite GPIO slave: OUT/OE/IN registers plus SET/CLR write aliases.
// The write and read channels run as independent two-process FSMs; every
// handshake and response signal is driven straight from a register.
module axi_lite_gpio_slave #(
    parameter int ADDR_W = 8,
    parameter int GPIO_W = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [GPIO_W-1:0] gpio_oe
);

    typedef enum logic [1:0] {
        W_IDLE    = 2'b00,
        W_HAVE_AW = 2'b01,
        W_HAVE_W  = 2'b10,
        W_RESP    = 2'b11
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    localparam logic [2:0] OFF_OUT = 3'd0;
    localparam logic [2:0] OFF_OE  = 3'd1;
    localparam logic [2:0] OFF_IN  = 3'd2;
    localparam logic [2:0] OFF_SET = 3'd3;
    localparam logic [2:0] OFF_CLR = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Expand the four byte strobes into a 32-bit lane mask.
    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] m;
        m = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                m[8*i +: 8] = 8'hFF;
            end
        end
        return m;
    endfunction

    // Zero-extend a GPIO-wide value onto the 32-bit data bus.
    function automatic logic [31:0] zext(input logic [GPIO_W-1:0] v);
        logic [31:0] t;
        t = 32'h0000_0000;
        t[GPIO_W-1:0] = v;
        return t;
    endfunction

    // OUT, OE, SET and CLR are the only writable offsets.
    function automatic logic [1:0] wr_resp(input logic [2:0] off);
        logic [1:0] r;
        case (off)
            OFF_OUT, OFF_OE, OFF_SET, OFF_CLR: r = RESP_OKAY;
            default:                           r = RESP_SLVERR;
        endcase
        return r;
    endfunction

    w_state_t          r_wstate;
    w_state_t          w_wstate_nxt;
    r_state_t          r_rstate;
    r_state_t          w_rstate_nxt;

    logic              r_awready;
    logic              r_wready;
    logic              r_bvalid;
    logic [1:0]        r_bresp;
    logic [2:0]        r_aw_off;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;

    logic              r_arready;
    logic              r_rvalid;
    logic [31:0]       r_rdata;
    logic [1:0]        r_rresp;

    logic [GPIO_W-1:0] r_out;
    logic [GPIO_W-1:0] r_oe;
    logic [GPIO_W-1:0] r_sync1;
    logic [GPIO_W-1:0] r_sync2;

    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_ar_hs;
    logic              w_commit;
    logic [2:0]        w_cmt_off;
    logic [31:0]       w_cmt_data;
    logic [3:0]        w_cmt_strb;
    logic [31:0]       w_byte_mask;
    logic [GPIO_W-1:0] w_lane;
    logic [GPIO_W-1:0] w_wbits;
    logic [GPIO_W-1:0] w_out_nxt;
    logic [GPIO_W-1:0] w_oe_nxt;
    logic [31:0]       w_rd_data;
    logic [1:0]        w_rd_resp;
    logic              w_unused;

    assign w_aw_hs = s_awvalid & r_awready;
    assign w_w_hs  = s_wvalid & r_wready;
    assign w_ar_hs = s_arvalid & r_arready;

    // A channel handshaking on the commit edge supplies its value directly;
    // otherwise the earlier captured copy is used.
    assign w_cmt_off   = w_aw_hs ? s_awaddr[4:2] : r_aw_off;
    assign w_cmt_data  = w_w_hs ? s_wdata : r_wdata;
    assign w_cmt_strb  = w_w_hs ? s_wstrb : r_wstrb;
    assign w_byte_mask = strb_to_mask(w_cmt_strb);
    assign w_lane      = w_byte_mask[GPIO_W-1:0];
    assign w_wbits     = w_cmt_data[GPIO_W-1:0] & w_lane;

    // Address bits outside [4:2] and data bits above GPIO_W are don't-care.
    assign w_unused = ^{s_awaddr, s_araddr, w_cmt_data, w_byte_mask};

    // Write FSM next state; the commit fires on the edge both halves are held.
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_commit     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_wstate_nxt = W_RESP;
                    w_commit     = 1'b1;
                end else if (w_aw_hs) begin
                    w_wstate_nxt = W_HAVE_AW;
                end else if (w_w_hs) begin
                    w_wstate_nxt = W_HAVE_W;
                end else begin
                    w_wstate_nxt = W_IDLE;
                end
            end
            W_HAVE_AW: begin
                if (w_w_hs) begin
                    w_wstate_nxt = W_RESP;
                    w_commit     = 1'b1;
                end else begin
                    w_wstate_nxt = W_HAVE_AW;
                end
            end
            W_HAVE_W: begin
                if (w_aw_hs) begin
                    w_wstate_nxt = W_RESP;
                    w_commit     = 1'b1;
                end else begin
                    w_wstate_nxt = W_HAVE_W;
                end
            end
            W_RESP: begin
                if (s_bready) begin
                    w_wstate_nxt = W_IDLE;
                end else begin
                    w_wstate_nxt = W_RESP;
                end
            end
            default: begin
                w_wstate_nxt = W_IDLE;
            end
        endcase
    end

    // Write FSM state, registered handshake outputs and captured AW/W halves.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_aw_off  <= 3'd0;
            r_wdata   <= 32'h0000_0000;
            r_wstrb   <= 4'h0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_awready <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_HAVE_W);
            r_wready  <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_HAVE_AW);
            r_bvalid  <= (w_wstate_nxt == W_RESP);
            if (w_aw_hs) begin
                r_aw_off <= s_awaddr[4:2];
            end
            if (w_w_hs) begin
                r_wdata <= s_wdata;
                r_wstrb <= s_wstrb;
            end
            if (w_commit) begin
                r_bresp <= wr_resp(w_cmt_off);
            end
        end
    end

    // Next OUT/OE values for a committing write; IN and unmapped are no-ops.
    always_comb begin
        w_out_nxt = r_out;
        w_oe_nxt  = r_oe;
        if (w_commit) begin
            case (w_cmt_off)
                OFF_OUT: w_out_nxt = (r_out & ~w_lane) | w_wbits;
                OFF_OE:  w_oe_nxt  = (r_oe & ~w_lane) | w_wbits;
                OFF_SET: w_out_nxt = r_out | w_wbits;
                OFF_CLR: w_out_nxt = r_out & ~w_wbits;
                default: begin
                    w_out_nxt = r_out;
                    w_oe_nxt  = r_oe;
                end
            endcase
        end else begin
            w_out_nxt = r_out;
            w_oe_nxt  = r_oe;
        end
    end

    // OUT and OE storage, which drive the pins directly.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_out <= '0;
            r_oe  <= '0;
        end else begin
            r_out <= w_out_nxt;
            r_oe  <= w_oe_nxt;
        end
    end

    // Two-flop synchronizer for the asynchronous pin inputs.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
        end
    end

    // Read data mux; uses current register values so a same-edge write is not seen.
    always_comb begin
        w_rd_data = 32'h0000_0000;
        w_rd_resp = RESP_OKAY;
        case (s_araddr[4:2])
            OFF_OUT: w_rd_data = zext(r_out);
            OFF_OE:  w_rd_data = zext(r_oe);
            OFF_IN:  w_rd_data = zext(r_sync2);
            OFF_SET, OFF_CLR: begin
                w_rd_data = 32'h0000_0000;
                w_rd_resp = RESP_OKAY;
            end
            default: begin
                w_rd_data = 32'h0000_0000;
                w_rd_resp = RESP_SLVERR;
            end
        endcase
    end

    // Read FSM next state.
    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE: begin
                if (w_ar_hs) begin
                    w_rstate_nxt = R_DATA;
                end else begin
                    w_rstate_nxt = R_IDLE;
                end
            end
            R_DATA: begin
                if (s_rready) begin
                    w_rstate_nxt = R_IDLE;
                end else begin
                    w_rstate_nxt = R_DATA;
                end
            end
            default: begin
                w_rstate_nxt = R_IDLE;
            end
        endcase
    end

    // Read FSM state, registered handshakes and the held read response.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'h0000_0000;
            r_rresp   <= 2'b00;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= (w_rstate_nxt == R_IDLE);
            r_rvalid  <= (w_rstate_nxt == R_DATA);
            if (w_ar_hs) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_resp;
            end
        end
    end

    assign s_awready = r_awready;
    assign s_wready  = r_wready;
    assign s_bvalid  = r_bvalid;
    assign s_bresp   = r_bresp;
    assign s_arready = r_arready;
    assign s_rvalid  = r_rvalid;
    assign s_rdata   = r_rdata;
    assign s_rresp   = r_rresp;
    assign gpio_out  = r_out;
    assign gpio_oe   = r_oe;

endmodule

// File: tb/tb_axi_lite_gpio_slave.sv
// Bench for axi_lite_gpio_slave: directed AXI-Lite transactions, a
// transaction-level register model checked every cycle, and literal pins.
module tb_axi_lite_gpio_slave;

    localparam int GPIO_W = 16;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [7:0]  s_awaddr = 8'h00;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [31:0] s_wdata = 32'h0;
    logic [3:0]  s_wstrb = 4'h0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready = 1'b0;
    logic [7:0]  s_araddr = 8'h00;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready = 1'b0;
    logic [15:0] gpio_in = 16'h0;
    logic [15:0] gpio_out;
    logic [15:0] gpio_oe;

    axi_lite_gpio_slave #(.ADDR_W(8), .GPIO_W(GPIO_W)) dut (
        .aclk(aclk), .areset(areset),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    wr_t         wq[$];
    logic [7:0]  rq[$];

    // Register model: plain 32-bit words holding what software would see.
    logic [31:0] m_out = 32'h0;
    logic [31:0] m_oe = 32'h0;
    logic [31:0] exp_rdata = 32'h0;
    logic [1:0]  exp_rresp = 2'b00;
    logic [1:0]  exp_bresp = 2'b00;
    logic        prev_b = 1'b0;
    logic        prev_r = 1'b0;
    logic        p_rst = 1'b1;

    localparam logic [31:0] GMASK = 32'((64'd1 << GPIO_W) - 64'd1);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired at %0t", nm, $time);
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] s);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++) if (s[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (a[4:2])
            3'd0:    return m_out;
            3'd1:    return m_oe;
            3'd2:    return {16'h0, gpio_in} & GMASK;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [1:0] m_rresp(input logic [7:0] a);
        return (a[4:2] <= 3'd4) ? 2'b00 : 2'b10;
    endfunction

    task automatic m_apply(input wr_t w);
        logic [31:0] v;
        v = w.data & lanes(w.strb) & GMASK;
        exp_bresp = 2'b00;
        case (w.addr[4:2])
            3'd0:    m_out = (m_out & ~(lanes(w.strb) & GMASK)) | v;
            3'd1:    m_oe  = (m_oe & ~(lanes(w.strb) & GMASK)) | v;
            3'd3:    m_out = m_out | v;
            3'd4:    m_out = m_out & ~v;
            default: exp_bresp = 2'b10;
        endcase
    endtask

    // Reset as sampled by the design at the most recent rising edge.
    always @(posedge aclk) p_rst <= areset;

    // Compare process: update the model on response rises, then check outputs.
    always @(negedge aclk) begin
        if (p_rst) begin
            m_out = 32'h0;
            m_oe  = 32'h0;
            wq.delete();
            rq.delete();
            chkb("rst_bvalid", s_bvalid, 1'b0);
            chkb("rst_rvalid", s_rvalid, 1'b0);
            chkb("rst_awready", s_awready, 1'b0);
            chkb("rst_arready", s_arready, 1'b0);
        end else begin
            if (s_rvalid && !prev_r) begin
                if (rq.size() == 0) begin
                    fail("r_unexpected");
                end else begin
                    exp_rdata = m_read(rq[0]);
                    exp_rresp = m_rresp(rq[0]);
                    void'(rq.pop_front());
                end
            end
            if (s_bvalid && !prev_b) begin
                if (wq.size() == 0) begin
                    fail("b_unexpected");
                end else begin
                    m_apply(wq.pop_front());
                end
            end
            if (s_rvalid) begin
                chk("rdata", s_rdata, exp_rdata);
                chk("rresp", {30'h0, s_rresp}, {30'h0, exp_rresp});
            end
            if (s_bvalid) begin
                chk("bresp", {30'h0, s_bresp}, {30'h0, exp_bresp});
            end
        end
        chk("gpio_out", {16'h0, gpio_out}, m_out);
        chk("gpio_oe", {16'h0, gpio_oe}, m_oe);
        prev_b = s_bvalid;
        prev_r = s_rvalid;
    end

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] st,
                      input int aw_at, input int w_at, input int bdly, output logic [1:0] br);
        bit aw_done, w_done, hs_aw, hs_w;
        int cyc;
        aw_done = 1'b0; w_done = 1'b0; cyc = 0; br = 2'b11;
        wq.push_back('{addr: a, data: d, strb: st});
        s_awaddr = a; s_wdata = d; s_wstrb = st;
        while (!(aw_done && w_done) && cyc < 40) begin
            s_awvalid = !aw_done && (cyc >= aw_at);
            s_wvalid  = !w_done && (cyc >= w_at);
            @(negedge aclk);
            if (w_done && !aw_done) chkb("wready_while_w_held", s_wready, 1'b0);
            if (aw_done && !w_done) chkb("awready_while_aw_held", s_awready, 1'b0);
            hs_aw = s_awvalid && s_awready;
            hs_w  = s_wvalid && s_wready;
            @(posedge aclk); #1;
            aw_done = aw_done | hs_aw;
            w_done  = w_done | hs_w;
            cyc++;
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        if (!(aw_done && w_done)) begin
            fail("wr_timeout");
            return;
        end
        chkb("b_latency", s_bvalid, 1'b1);
        br = s_bresp;
        for (int i = 0; i < bdly; i++) begin
            chkb("awready_in_resp", s_awready, 1'b0);
            chkb("wready_in_resp", s_wready, 1'b0);
            @(posedge aclk); #1;
            chkb("b_hold", s_bvalid, 1'b1);
        end
        s_bready = 1'b1;
        @(posedge aclk); #1;
        s_bready = 1'b0;
        chkb("b_done", s_bvalid, 1'b0);
        chkb("awready_back", s_awready, 1'b1);
        chkb("wready_back", s_wready, 1'b1);
    endtask

    task automatic rd(input logic [7:0] a, input int rdly, output logic [31:0] d, output logic [1:0] r);
        bit done;
        int cyc;
        done = 1'b0; cyc = 0; d = 32'hDEAD_DEAD; r = 2'b11;
        rq.push_back(a);
        s_araddr = a; s_arvalid = 1'b1;
        while (!done && cyc < 40) begin
            @(negedge aclk);
            done = s_arready;
            @(posedge aclk); #1;
            cyc++;
        end
        s_arvalid = 1'b0;
        if (!done) begin
            fail("rd_timeout");
            return;
        end
        chkb("r_latency", s_rvalid, 1'b1);
        d = s_rdata; r = s_rresp;
        for (int i = 0; i < rdly; i++) begin
            @(posedge aclk); #1;
            chkb("r_hold", s_rvalid, 1'b1);
        end
        s_rready = 1'b1;
        @(posedge aclk); #1;
        s_rready = 1'b0;
        chkb("r_done", s_rvalid, 1'b0);
        chkb("arready_back", s_arready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  br, rr;
        logic [31:0] rd_d;

        // Reset, then readies must come up on the first edge after release.
        repeat (3) @(posedge aclk);
        #1;
        chkb("reset_awready", s_awready, 1'b0);
        chk("reset_gpio_out", {16'h0, gpio_out}, 32'h0);
        areset = 1'b0;
        @(posedge aclk); #1;
        chkb("post_rst_awready", s_awready, 1'b1);
        chkb("post_rst_wready", s_wready, 1'b1);
        chkb("post_rst_arready", s_arready, 1'b1);

        // AW and W together.
        wr(8'h00, 32'h0000_0055, 4'hF, 0, 0, 0, br);
        chk("lit_out_55", {16'h0, gpio_out}, 32'h0000_0055);
        chk("lit_bresp_out", {30'h0, br}, 32'h0);

        // W three cycles ahead of AW, B stalled four cycles.
        wr(8'h04, 32'h0000_FFFF, 4'h1, 3, 0, 4, br);
        chk("lit_oe_ff", {16'h0, gpio_oe}, 32'h0000_00FF);

        // SET/CLR sequence, including partial strobes.
        wr(8'h00, 32'h0000_00AA, 4'hF, 1, 0, 1, br);
        wr(8'h0C, 32'h0000_0F00, 4'hF, 0, 2, 0, br);
        wr(8'h10, 32'h0000_000A, 4'hF, 0, 0, 0, br);
        chk("lit_out_fa0", {16'h0, gpio_out}, 32'h0000_0FA0);
        rd(8'h00, 0, rd_d, rr);
        chk("lit_rd_fa0", rd_d, 32'h0000_0FA0);
        chk("lit_rresp_ok", {30'h0, rr}, 32'h0);
        wr(8'h0C, 32'hFFFF_FFFF, 4'b0010, 0, 0, 0, br);
        wr(8'h10, 32'h0000_FFFF, 4'b0001, 0, 0, 0, br);
        chk("lit_out_ff00", {16'h0, gpio_out}, 32'h0000_FF00);

        // IN register, read-only and unmapped offsets, address aliasing.
        gpio_in = 16'h1234;
        repeat (4) @(posedge aclk);
        #1;
        rd(8'h08, 2, rd_d, rr);
        chk("lit_in_1234", rd_d, 32'h0000_1234);
        wr(8'h08, 32'h0000_FFFF, 4'hF, 0, 0, 0, br);
        chk("lit_bresp_in", {30'h0, br}, 32'h2);
        rd(8'h08, 0, rd_d, rr);
        chk("lit_in_kept", rd_d, 32'h0000_1234);
        rd(8'h18, 1, rd_d, rr);
        chk("lit_unmapped_data", rd_d, 32'h0);
        chk("lit_unmapped_resp", {30'h0, rr}, 32'h2);
        wr(8'h1C, 32'h0000_FFFF, 4'hF, 0, 0, 0, br);
        chk("lit_bresp_unmapped", {30'h0, br}, 32'h2);
        rd(8'h0C, 0, rd_d, rr);
        chk("lit_set_reads_0", rd_d, 32'h0);
        rd(8'h24, 0, rd_d, rr);
        chk("lit_alias_oe", rd_d, 32'h0000_00FF);
        rd(8'h07, 0, rd_d, rr);
        chk("lit_lowbits_oe", rd_d, 32'h0000_00FF);

        // Read capture coinciding with a write commit to the same register.
        wq.push_back('{addr: 8'h00, data: 32'h0000_BEEF, strb: 4'hF});
        rq.push_back(8'h00);
        s_awaddr = 8'h00; s_wdata = 32'h0000_BEEF; s_wstrb = 4'hF; s_araddr = 8'h00;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        @(posedge aclk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        chkb("coll_bvalid", s_bvalid, 1'b1);
        chkb("coll_rvalid", s_rvalid, 1'b1);
        chk("lit_coll_old", s_rdata, 32'h0000_FF00);
        s_bready = 1'b1; s_rready = 1'b1;
        @(posedge aclk); #1;
        s_bready = 1'b0; s_rready = 1'b0;
        rd(8'h00, 0, rd_d, rr);
        chk("lit_coll_new", rd_d, 32'h0000_BEEF);

        // Upper bits of a write are discarded.
        wr(8'h00, 32'hABCD_1234, 4'hF, 0, 0, 0, br);
        rd(8'h00, 0, rd_d, rr);
        chk("lit_upper_discard", rd_d, 32'h0000_1234);

        // Reset while both responses are pending.
        wq.push_back('{addr: 8'h04, data: 32'h0000_00F0, strb: 4'hF});
        rq.push_back(8'h00);
        s_awaddr = 8'h04; s_wdata = 32'h0000_00F0; s_araddr = 8'h00;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        @(posedge aclk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        chkb("pre_rst_bvalid", s_bvalid, 1'b1);
        chkb("pre_rst_rvalid", s_rvalid, 1'b1);
        areset = 1'b1;
        @(posedge aclk); #1;
        chkb("mid_rst_bvalid", s_bvalid, 1'b0);
        chkb("mid_rst_rvalid", s_rvalid, 1'b0);
        chk("lit_rst_out", {16'h0, gpio_out}, 32'h0);
        chk("lit_rst_oe", {16'h0, gpio_oe}, 32'h0);
        areset = 1'b0;
        @(posedge aclk); #1;
        chkb("rel_awready", s_awready, 1'b1);
        chkb("rel_wready", s_wready, 1'b1);
        chkb("rel_arready", s_arready, 1'b1);

        // Normal operation resumes after reset.
        wr(8'h00, 32'h0000_0003, 4'hF, 0, 0, 0, br);
        chk("lit_after_rst", {16'h0, gpio_out}, 32'h0000_0003);
        repeat (2) @(posedge aclk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
